// File: rtl/vend_dispense_sequencer.sv
// rtl/vend_dispense_sequencer.sv - soda motor pulse then coin-by-coin change payout with stall timeouts
// Optional feature macro: VEND_DIME_HOPPER_EN (dime hopper path; nickel-only payout when undefined)
module vend_dispense_sequencer #(
    parameter int MAX_CHANGE  = 20,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [4:0] req_change,
    output logic       req_ready,
    output logic       soda_motor,
    input  logic       motor_done,
    output logic       hopper_dime,
    output logic       hopper_nick,
    input  logic       hopper_ack,
    output logic       vend_done,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       err_clr,
    output logic [2:0] state_test
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOTOR  = 3'd1,
        MWAIT  = 3'd2,
        PAYSEL = 3'd3,
        PAY    = 3'd4,
        PWAIT  = 3'd5,
        DONE   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    localparam int CNT_MAX = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] TMO_END   = CW'(TIMEOUT_CYC - 1);
    localparam logic [4:0]    MAX_C     = 5'(MAX_CHANGE);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [4:0]    rem;
    logic          bad_change;
    logic          pulse_end;
    logic          timeout;
    logic [4:0]    coin_val;

    assign bad_change = (req_change > MAX_C) || ((req_change % 5'd5) != 5'd0);
    assign pulse_end  = (cnt == PULSE_END);
    assign timeout    = (cnt == TMO_END);

`ifdef VEND_DIME_HOPPER_EN
    logic coin_dime;
    assign coin_val    = coin_dime ? 5'd10 : 5'd5;
    assign hopper_dime = (state == PAY) && coin_dime;
    assign hopper_nick = (state == PAY) && !coin_dime;
`else
    assign coin_val    = 5'd5;
    assign hopper_dime = 1'b0;
    assign hopper_nick = (state == PAY);
`endif

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        soda_motor = 1'b0;
        vend_done  = 1'b0;
        busy       = 1'b1;
        err        = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = bad_change ? FAULT : MOTOR;
            end
            MOTOR: begin
                soda_motor = 1'b1;
                if (pulse_end)
                    state_nxt = MWAIT;
            end
            MWAIT: begin
                if (motor_done)
                    state_nxt = PAYSEL;
                else if (timeout)
                    state_nxt = FAULT;
            end
            PAYSEL: begin
                // rem is always a multiple of 5, so anything below a nickel means done
                state_nxt = (rem >= 5'd5) ? PAY : DONE;
            end
            PAY: begin
                if (pulse_end)
                    state_nxt = PWAIT;
            end
            PWAIT: begin
                if (hopper_ack)
                    state_nxt = PAYSEL;
                else if (timeout)
                    state_nxt = FAULT;
            end
            DONE: begin
                vend_done = 1'b1;
                state_nxt = IDLE;
            end
            FAULT: begin
                busy = 1'b0;
                err  = 1'b1;
                if (err_clr)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            err_code <= 2'b00;
`ifdef VEND_DIME_HOPPER_EN
            coin_dime <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            // one counter serves both pulse width and wait timeout; it restarts on every state change
            if (state_nxt != state)
                cnt <= '0;
            else if (cnt != CNT_SAT)
                cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (bad_change) err_code <= 2'b01;
                        else            rem      <= req_change;
                    end
                end
                MWAIT: begin
                    if (!motor_done && timeout) err_code <= 2'b10;
                end
`ifdef VEND_DIME_HOPPER_EN
                PAYSEL: coin_dime <= (rem >= 5'd10);
`endif
                PWAIT: begin
                    if (hopper_ack)   rem      <= rem - coin_val;
                    else if (timeout) err_code <= 2'b11;
                end
                FAULT: begin
                    if (err_clr) begin
                        err_code <= 2'b00;
                        rem      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_test = state;

endmodule
